systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the array dimension (N x N).
REQ-002 The block SHALL have parameter W, default 32, giving the element width in bits.
REQ-003 The block SHALL have parameter DRAIN, default 2*N, giving the number of zero-feed cycles after the last operand.
REQ-004 clock  input  1  sole clock; all state updates occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to run one multiply; sampled only while ready=1.
REQ-007 abort  input  1  synchronous cancel of a run in progress.
REQ-008 a_mat  input  N*N*W  operand A, indexed [row][col]; captured on the accepted start edge.
REQ-009 b_mat  input  N*N*W  operand B, indexed [row][col]; captured on the accepted start edge.
REQ-010 ready  output 1  high only in IDLE.
REQ-011 done  output 1  one-cycle pulse when the result is registered.
REQ-012 sa_reset  output 1  clears the array accumulators.
REQ-013 sa_A  output N*W  row-edge operand feed to the array, indexed [i].
REQ-014 sa_B  output N*W  column-edge operand feed to the array, indexed [j].
REQ-015 sa_Out  input  N*N*W  array accumulator outputs, indexed [i][j].
REQ-016 result  output N*N*W  captured product, indexed [i][j].
REQ-017 result_valid  output 1  high while result holds a completed product.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, CAPTURE, with transitions in that order and CAPTURE returning to IDLE.
REQ-019 IDLE with start=1 SHALL latch a_mat and b_mat, clear result_valid, and enter CLEAR on the same edge.
REQ-020 start while not in IDLE SHALL be ignored, with no effect on state, operands or outputs.
REQ-021 CLEAR SHALL last exactly 1 cycle with sa_reset=1 and sa_A=sa_B=0.
REQ-022 FEED SHALL last exactly 2N-1 cycles, numbered t=0..2N-2.
REQ-023 In FEED cycle t, sa_A[i] SHALL equal A[i][t-i] when 0<=t-i<N, else 0.
REQ-024 In FEED cycle t, sa_B[j] SHALL equal B[t-j][j] when 0<=t-j<N, else 0.
REQ-025 DRAIN SHALL last exactly DRAIN cycles with sa_A=sa_B=0.
REQ-026 CAPTURE SHALL last 1 cycle, after which the next edge loads result from sa_Out, sets result_valid=1, pulses done for 1 cycle, and returns to IDLE.
REQ-027 Latency SHALL be fixed: done high in the cycle beginning (2N+1+DRAIN) edges after the start-accepting edge (9 edges for N=2, DRAIN=4).
REQ-028 sa_A, sa_B and sa_reset SHALL be registered outputs, except that sa_reset is also forced high combinationally while reset=1.
REQ-029 result SHALL pass sa_Out through unchanged at W bits, with wraparound (overflow) left to the array.
REQ-030 result and result_valid SHALL hold until the next accepted start.
REQ-031 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, drive sa_A=sa_B=0, keep result_valid=0, and suppress done.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 abort and start asserted together in IDLE SHALL give priority to abort, so no run starts.
REQ-034 start asserted in the same cycle as the done pulse SHALL be accepted, because ready=1 then.

Reset
REQ-035 While reset=1, the block SHALL force state=IDLE, ready=1, done=0, result_valid=0, result=0, sa_A=0, sa_B=0, sa_reset=1.
REQ-036 Reset asserted mid-run SHALL take effect immediately; after release the block SHALL be in IDLE with no done pulse.

Verification
REQ-037 N=2, W=32, DRAIN=4, A=[[6,3],[5,4]], B=[[10,8],[2,1]], pulse start -> feed sequence sa_A {6,0},{3,5},{0,4} and sa_B {10,0},{2,8},{0,1}; done on edge 9; result=[[66,51],[58,44]]; result_valid=1.
REQ-038 Pulse start again at edge 3 of a run -> ignored; single done pulse at edge 9.
REQ-039 Assert abort during DRAIN -> next cycle ready=1, result_valid=0, no done pulse; a following run with the same operands still yields [[66,51],[58,44]].
REQ-040 Assert reset during FEED -> all outputs reach reset values immediately; sa_reset=1; ready=1 after release.
REQ-041 Hold start high continuously for two runs -> back-to-back runs with done 10 edges apart; result updates only at each done.
REQ-042 A=[[0xFFFFFFFF,0],[0,0]], B=[[2,0],[0,0]] -> result[0][0]=0xFFFFFFFE (wrap), all other entries 0.

Source files
------------

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences one N x N matrix multiply through an output-stationary systolic array
//   clock, reset (async, active-high) | start/abort: run control | ready: idle, done: result pulse
//   a_mat/b_mat: operands [row][col] | sa_reset/sa_A/sa_B: array control and skewed edge feeds
//   sa_Out: array accumulators [i][j] | result/result_valid: captured product
module systolic_ctrl #(
  parameter int N = 2,
  parameter int W = 32,
  parameter int DRAIN = 2*N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [N*N*W-1:0] a_mat,
  input  logic [N*N*W-1:0] b_mat,
  output logic             ready,
  output logic             done,
  output logic             sa_reset,
  output logic [N*W-1:0]   sa_A,
  output logic [N*W-1:0]   sa_B,
  input  logic [N*N*W-1:0] sa_Out,
  output logic [N*N*W-1:0] result,
  output logic             result_valid
);
  localparam int CW = $clog2(2*N + DRAIN + 1) + 1;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_CAPTURE} state_t;
  state_t state;
  logic [CW-1:0] cnt, tn;
  logic [N*N*W-1:0] a_q, b_q;
  logic [N*W-1:0] feed_a, feed_b;
  logic sa_reset_q;
  assign ready = state == S_IDLE;
  assign sa_reset = sa_reset_q | reset;
  // feed values for the cycle about to start: row i sees A[i][t-i], column j sees B[t-j][j]
  always_comb begin
    tn = state == S_CLEAR ? '0 : cnt + 1'b1;
    feed_a = '0;
    feed_b = '0;
    for (int i = 0; i < N; i++)
      if (int'(tn) >= i && int'(tn) - i < N) begin
        feed_a[i*W +: W] = a_q[(i*N + int'(tn) - i)*W +: W];
        feed_b[i*W +: W] = b_q[((int'(tn) - i)*N + i)*W +: W];
      end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      sa_A <= '0;
      sa_B <= '0;
      sa_reset_q <= 1'b0;
      done <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      sa_reset_q <= 1'b0;
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
        sa_A <= '0;
        sa_B <= '0;
        result_valid <= 1'b0;
      end else
        case (state)
          S_IDLE:
            if (start && !abort) begin
              a_q <= a_mat;
              b_q <= b_mat;
              result_valid <= 1'b0;
              sa_reset_q <= 1'b1;
              sa_A <= '0;
              sa_B <= '0;
              state <= S_CLEAR;
            end
          S_CLEAR: begin
            cnt <= '0;
            sa_A <= feed_a;
            sa_B <= feed_b;
            state <= S_FEED;
          end
          S_FEED:
            if (cnt == CW'(2*N - 2)) begin
              cnt <= '0;
              sa_A <= '0;
              sa_B <= '0;
              state <= DRAIN > 0 ? S_DRAIN : S_CAPTURE;
            end else begin
              cnt <= cnt + 1'b1;
              sa_A <= feed_a;
              sa_B <= feed_b;
            end
          S_DRAIN: begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DRAIN - 1)) state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            result <= sa_Out;
            result_valid <= 1'b1;
            done <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed and random runs of systolic_ctrl driving a behavioural systolic array
module tb_systolic_ctrl;
  localparam int N = 2, W = 32, DRAIN = 4, LAT = 2*N + 1 + DRAIN;
  logic clock = 1'b0, reset, start, abort;
  logic [N*N*W-1:0] a_mat, b_mat, sa_Out, result;
  logic ready, done, sa_reset, result_valid;
  logic [N*W-1:0] sa_A, sa_B;
  logic [W-1:0] am[N][N], bm[N][N], acc[N][N], pa[N][N], pb[N][N];
  logic [W-1:0] ai, bi;
  logic [N*N*W-1:0] exp1, exp2;
  int n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  systolic_ctrl #(.N(N), .W(W), .DRAIN(DRAIN)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .a_mat(a_mat), .b_mat(b_mat), .ready(ready), .done(done),
    .sa_reset(sa_reset), .sa_A(sa_A), .sa_B(sa_B), .sa_Out(sa_Out),
    .result(result), .result_valid(result_valid)
  );

  // output-stationary array: A flows right, B flows down, each PE accumulates a*b
  always @(posedge clock)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (j == 0) ai = sa_A[i*W +: W]; else ai = pa[i][j-1];
        if (i == 0) bi = sa_B[j*W +: W]; else bi = pb[i-1][j];
        if (sa_reset) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j] <= ai;
          pb[i][j] <= bi;
          acc[i][j] <= acc[i][j] + ai * bi;
        end
      end

  always_comb begin
    sa_Out = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sa_Out[(i*N + j)*W +: W] = acc[i][j];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N*N*W-1:0] obs, input logic [N*N*W-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pack_ops;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_mat[(r*N + c)*W +: W] = am[r][c];
        b_mat[(r*N + c)*W +: W] = bm[r][c];
      end
  endtask

  function automatic logic [N*N*W-1:0] product();
    logic [N*N*W-1:0] r;
    logic [W-1:0] s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + am[i][k] * bm[k][j];
        r[(i*N + j)*W +: W] = s;
      end
    return r;
  endfunction

  function automatic logic [N*W-1:0] feed_exp(input bit is_a, input int t);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*W +: W] = is_a ? am[i][t-i] : bm[t-i][i];
    return r;
  endfunction

  task automatic run(input int restart_at);
    logic [N*N*W-1:0] exp_r;
    exp_r = product();
    pack_ops();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_ready", ready, 0);
    chk("clear_sa_reset", sa_reset, 1);
    chk("clear_sa_A", sa_A, 0);
    chk("clear_sa_B", sa_B, 0);
    chk("clear_result_valid", result_valid, 0);
    for (int e = 1; e <= LAT; e++) begin
      start = e == restart_at;
      tick();
      start = 1'b0;
      if (e < LAT) begin
        chk("run_done", done, 0);
        chk("run_ready", ready, 0);
        chk("run_sa_reset", sa_reset, 0);
        chk("feed_A", sa_A, feed_exp(1'b1, e - 1));
        chk("feed_B", sa_B, feed_exp(1'b0, e - 1));
      end else begin
        chk("done", done, 1);
        chk("done_ready", ready, 1);
        chk("done_result_valid", result_valid, 1);
        chk("result", result, exp_r);
      end
    end
    tick();
    chk("done_one_cycle", done, 0);
    chk("result_hold", result, exp_r);
  endtask

  task automatic set_ref;
    am = '{'{32'd6, 32'd3}, '{32'd5, 32'd4}};
    bm = '{'{32'd10, 32'd8}, '{32'd2, 32'd1}};
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a_mat = '0;
    b_mat = '0;
    tick();
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sa_A", sa_A, 0);
    chk("rst_sa_B", sa_B, 0);
    chk("rst_sa_reset", sa_reset, 1);
    reset = 1'b0;
    tick();
    // reference multiply
    set_ref();
    run(-1);
    chk("ref_result", result, {32'd44, 32'd58, 32'd51, 32'd66});
    // start during a run is ignored
    run(3);
    // abort and start together in idle: nothing starts, old result kept
    abort = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle_ready", ready, 1);
    chk("abort_idle_result_valid", result_valid, 1);
    tick();
    chk("abort_start_idle_ready2", ready, 1);
    // abort during drain
    pack_ops();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_result_valid", result_valid, 0);
    chk("abort_sa_A", sa_A, 0);
    chk("abort_sa_B", sa_B, 0);
    chk("abort_done", done, 0);
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    run(-1);
    chk("after_abort_result", result, {32'd44, 32'd58, 32'd51, 32'd66});
    // reset during feed
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_result_valid", result_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_sa_A", sa_A, 0);
    chk("midrst_sa_B", sa_B, 0);
    chk("midrst_sa_reset", sa_reset, 1);
    tick();
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk("midrst_no_done", done, 0);
      chk("midrst_idle", ready, 1);
    end
    // start held high: back-to-back runs, done 10 edges apart
    set_ref();
    exp1 = product();
    pack_ops();
    start = 1'b1;
    for (int e = 0; e <= 2*LAT + 3; e++) begin
      tick();
      if (e == 0) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            am[r][c] = $urandom_range(0, 1000);
            bm[r][c] = $urandom_range(0, 1000);
          end
        exp2 = product();
        pack_ops();
      end
      chk("b2b_done", done, (e == LAT || e == 2*LAT + 1) ? 1 : 0);
      if (e == LAT) chk("b2b_result1", result, exp1);
      if (e == LAT + 5) begin
        chk("b2b_result_held", result, exp1);
        chk("b2b_valid_cleared", result_valid, 0);
      end
      if (e == 2*LAT + 1) begin
        chk("b2b_result2", result, exp2);
        chk("b2b_valid", result_valid, 1);
      end
      if (e == 2*LAT) start = 1'b0;
    end
    // W-bit wraparound
    am = '{'{32'hFFFFFFFF, 32'd0}, '{32'd0, 32'd0}};
    bm = '{'{32'd2, 32'd0}, '{32'd0, 32'd0}};
    run(-1);
    chk("wrap_result", result, {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE});
    // random operands
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          am[r][c] = n < 3 ? $urandom_range(0, 255) : $urandom;
          bm[r][c] = n < 3 ? $urandom_range(0, 255) : $urandom;
        end
      run(-1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
